// File: rtl/mil_receiver.sv
// rtl/mil_receiver.sv - MIL-STD-1553 Manchester-II receiver
// Decodes RXin/nRXin into 16-bit typed words and offers them through a request/done holding register.
module mil_receiver #(
    parameter int HALF_BIT = 12,
    parameter int TOL      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RXin,
    input  logic        nRXin,
    output logic [15:0] dataOut,
    output logic [1:0]  dataType,
    output logic        outRequest,
    input  logic        outDone,
    output logic        busy,
    output logic        overflow
);

    localparam logic [1:0] WSERV    = 2'd0;
    localparam logic [1:0] WDATA    = 2'd1;
    localparam logic [1:0] WSERVERR = 2'd2;
    localparam logic [1:0] WDATAERR = 2'd3;

    localparam logic [1:0] LV_H = 2'b10;
    localparam logic [1:0] LV_L = 2'b01;

    localparam logic [6:0] SYNC_LO  = 7'(3*HALF_BIT - TOL);
    localparam logic [6:0] SYNC_HI  = 7'(3*HALF_BIT + TOL);
    localparam logic [6:0] MERGE_LO = 7'(4*HALF_BIT - TOL);
    localparam logic [6:0] MERGE_HI = 7'(4*HALF_BIT + TOL);

    localparam logic [5:0] SYNC2_MIN = 6'(3*HALF_BIT - TOL);
    localparam logic [5:0] SYNC2_END = 6'(3*HALF_BIT - 1);
    localparam logic [5:0] BIT_END   = 6'(2*HALF_BIT - 1);
    localparam logic [5:0] SAMP1     = 6'(HALF_BIT/2);
    localparam logic [5:0] SAMP2     = 6'(HALF_BIT + HALF_BIT/2);
    localparam logic [5:0] MID_LO    = 6'(HALF_BIT - TOL);
    localparam logic [5:0] MID_HI    = 6'(HALF_BIT + TOL);
    localparam logic [5:0] MID_NEXT  = 6'(HALF_BIT + 1);

    typedef enum logic [1:0] {HUNT, SYNC2, DATA, PARITY} state_t;

    state_t      state;
    logic [1:0]  rx_meta;
    logic [1:0]  lvl;
    logic [1:0]  lvl_prev;
    logic [6:0]  lvl_cnt;
    logic [5:0]  bcnt;
    logic [3:0]  bitidx;
    logic [1:0]  h1;
    logic        svc;
    logic [15:0] sh;
    logic        wv;
    logic [15:0] wdata;
    logic [1:0]  wtype;

    logic changed;
    logic prev_valid;
    logic lvl_valid;
    logic opposite;
    logic sync_len_ok;
    logic man_err;
    logic bit_val;
    logic [1:0] s2_lvl;

    always_comb begin
        lvl_valid  = (lvl == LV_H) || (lvl == LV_L);
        prev_valid = (lvl_prev == LV_H) || (lvl_prev == LV_L);
        changed    = (lvl != lvl_prev);
        opposite   = prev_valid && (lvl == {lvl_prev[0], lvl_prev[1]});
        // A 4H level is a sync half merged with the preceding parity second half of equal level.
        sync_len_ok = ((lvl_cnt >= SYNC_LO) && (lvl_cnt <= SYNC_HI)) ||
                      ((lvl_cnt >= MERGE_LO) && (lvl_cnt <= MERGE_HI));
        man_err = !((h1 == LV_H) || (h1 == LV_L)) || !lvl_valid || (h1 == lvl);
        bit_val = (h1 == LV_H);
        s2_lvl  = svc ? LV_L : LV_H;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            rx_meta    <= '0;
            lvl        <= '0;
            lvl_prev   <= '0;
            lvl_cnt    <= '0;
            bcnt       <= '0;
            bitidx     <= '0;
            h1         <= '0;
            svc        <= 1'b0;
            sh         <= '0;
            wv         <= 1'b0;
            wdata      <= '0;
            wtype      <= '0;
            dataOut    <= '0;
            dataType   <= '0;
            outRequest <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rx_meta  <= {RXin, nRXin};
            lvl      <= rx_meta;
            lvl_prev <= lvl;
            if (changed)
                lvl_cnt <= 7'd1;
            else if (lvl_cnt != 7'h7f)
                lvl_cnt <= lvl_cnt + 7'd1;

            wv       <= 1'b0;
            overflow <= 1'b0;

            case (state)
                HUNT: begin
                    if (changed && opposite && sync_len_ok) begin
                        state  <= SYNC2;
                        busy   <= 1'b1;
                        svc    <= (lvl_prev == LV_H);
                        bcnt   <= 6'd1;
                        bitidx <= 4'd15;
                        sh     <= '0;
                    end
                end
                SYNC2: begin
                    if ((bcnt < SYNC2_MIN) && (lvl != s2_lvl)) begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end else if (bcnt == SYNC2_END) begin
                        state <= DATA;
                        bcnt  <= '0;
                    end else begin
                        bcnt <= bcnt + 6'd1;
                    end
                end
                DATA, PARITY: begin
                    // Mid-bit edges near the expected point pull the timer back into phase.
                    if (changed && (bcnt >= MID_LO) && (bcnt <= MID_HI))
                        bcnt <= MID_NEXT;
                    else if (bcnt == BIT_END)
                        bcnt <= '0;
                    else
                        bcnt <= bcnt + 6'd1;

                    if (bcnt == SAMP1)
                        h1 <= lvl;

                    if (bcnt == SAMP2) begin
                        if (man_err) begin
                            wv    <= 1'b1;
                            wdata <= sh;
                            wtype <= svc ? WSERVERR : WDATAERR;
                            state <= HUNT;
                            busy  <= 1'b0;
                        end else if (state == DATA) begin
                            sh[bitidx] <= bit_val;
                            bitidx     <= bitidx - 4'd1;
                            if (bitidx == 4'd0)
                                state <= PARITY;
                        end else begin
                            wv    <= 1'b1;
                            wdata <= sh;
                            if ((^sh) ^ bit_val)
                                wtype <= svc ? WSERV : WDATA;
                            else
                                wtype <= svc ? WSERVERR : WDATAERR;
                            state <= HUNT;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                end
            endcase

            if (wv) begin
                if (!outRequest || outDone) begin
                    dataOut    <= wdata;
                    dataType   <= wtype;
                    outRequest <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (outDone && outRequest) begin
                outRequest <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mil_receiver.sv
// tb/tb_mil_receiver.sv - directed self-checking bench for mil_receiver
module tb_mil_receiver;

    localparam logic [1:0] WSERV    = 2'd0;
    localparam logic [1:0] WDATA    = 2'd1;
    localparam logic [1:0] WSERVERR = 2'd2;
    localparam logic [1:0] WDATAERR = 2'd3;

    logic        clk;
    logic        rst;
    logic        RXin;
    logic        nRXin;
    logic [15:0] dataOut;
    logic [1:0]  dataType;
    logic        outRequest;
    logic        outDone;
    logic        busy;
    logic        overflow;

    int vectors;
    int miscompares;
    int ovf_cnt;
    logic busy_sync;
    logic busy_mid;
    logic busy_q;
    logic hit;

    mil_receiver #(.HALF_BIT(12), .TOL(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .RXin       (RXin),
        .nRXin      (nRXin),
        .dataOut    (dataOut),
        .dataType   (dataType),
        .outRequest (outRequest),
        .outDone    (outDone),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (overflow) ovf_cnt++;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic odd_par(input logic [15:0] d);
        return ~^d;
    endfunction

    task automatic drive(input logic v, input int n);
        RXin  = v;
        nRXin = ~v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RXin  = 1'b0;
        nRXin = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic svc, input logic [15:0] d, input logic p,
                             input int bad, input int sync_len);
        drive(svc, sync_len);
        drive(~svc, 18);
        busy_sync = busy;
        drive(~svc, 18);
        for (int i = 15; i >= 0; i--) begin
            if (i == bad) begin
                drive(1'b1, 24);
            end else begin
                drive(d[i], 12);
                drive(~d[i], 12);
            end
            if (i == 8) busy_mid = busy;
        end
        drive(p, 12);
        drive(~p, 12);
    endtask

    task automatic wait_req(input string tag, input int max);
        int n;
        n = 0;
        while (!outRequest && n < max) begin
            @(negedge clk);
            n++;
        end
        expect_eq(tag, outRequest, 1);
    endtask

    task automatic take();
        outDone = 1'b1;
        @(negedge clk);
        outDone = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; ovf_cnt = 0;
        rst = 1'b1; RXin = 1'b0; nRXin = 1'b0; outDone = 1'b0;
        busy_sync = 1'b0; busy_mid = 1'b0; busy_q = 1'b0; hit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_eq("rst_req", outRequest, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_data", dataOut, 16'h0000);
        expect_eq("rst_ovf", overflow, 0);
        idle(10);

        // 1: data word 0xA5C3, good parity
        send_word(1'b0, 16'hA5C3, odd_par(16'hA5C3), -1, 36);
        wait_req("t1_req", 2);
        expect_eq("t1_data", dataOut, 16'hA5C3);
        expect_eq("t1_type", dataType, WDATA);
        idle(5);
        expect_eq("t1_hold", outRequest, 1);
        take();
        expect_eq("t1_release", outRequest, 0);
        idle(20);

        // 2: service word 0x0000, busy across the word
        send_word(1'b1, 16'h0000, 1'b1, -1, 36);
        wait_req("t2_req", 2);
        expect_eq("t2_type", dataType, WSERV);
        expect_eq("t2_data", dataOut, 16'h0000);
        expect_eq("t2_busy_sync", busy_sync, 1);
        expect_eq("t2_busy_mid", busy_mid, 1);
        expect_eq("t2_busy_end", busy, 0);
        take();
        idle(20);

        // 3: bad parity, then an over-long sync
        send_word(1'b0, 16'hFFFF, 1'b0, -1, 36);
        wait_req("t3_req", 2);
        expect_eq("t3_type", dataType, WDATAERR);
        expect_eq("t3_data", dataOut, 16'hFFFF);
        take();
        idle(20);
        send_word(1'b0, 16'hFFFF, 1'b1, -1, 39);
        idle(10);
        expect_eq("t3_longsync_req", outRequest, 0);
        expect_eq("t3_longsync_busy", busy, 0);
        idle(10);

        // 4: Manchester error in bit 7, back-to-back service word behind it
        fork
            begin
                send_word(1'b0, 16'h1234, odd_par(16'h1234), 7, 36);
                send_word(1'b1, 16'h8001, odd_par(16'h8001), -1, 36);
            end
            begin
                wait_req("t4_err_req", 700);
                expect_eq("t4_err_type", dataType, WDATAERR);
                expect_eq("t4_err_data", dataOut, 16'h1200);
                take();
            end
        join
        wait_req("t4_svc_req", 2);
        expect_eq("t4_svc_type", dataType, WSERV);
        expect_eq("t4_svc_data", dataOut, 16'h8001);
        expect_eq("t4_no_ovf", ovf_cnt, 0);
        take();
        idle(20);

        // 5: overflow on a full register, then reload with outDone in the completion clk
        send_word(1'b0, 16'h1111, odd_par(16'h1111), -1, 36);
        wait_req("t5_a_req", 2);
        idle(20);
        send_word(1'b0, 16'h2222, odd_par(16'h2222), -1, 36);
        idle(5);
        expect_eq("t5_ovf_pulse", ovf_cnt, 1);
        expect_eq("t5_held_data", dataOut, 16'h1111);
        expect_eq("t5_held_req", outRequest, 1);
        idle(20);
        fork
            send_word(1'b0, 16'h3333, odd_par(16'h3333), -1, 36);
            begin
                busy_q = busy;
                for (int n = 0; n < 1500 && !hit; n++) begin
                    @(negedge clk);
                    if (busy_q && !busy) begin
                        hit = 1'b1;
                        outDone = 1'b1;
                        @(negedge clk);
                        outDone = 1'b0;
                        expect_eq("t5_c_req_stays", outRequest, 1);
                        expect_eq("t5_c_data", dataOut, 16'h3333);
                    end
                    busy_q = busy;
                end
                expect_eq("t5_c_complete_seen", hit, 1);
            end
        join
        expect_eq("t5_c_no_ovf", ovf_cnt, 1);
        expect_eq("t5_c_type", dataType, WDATA);
        idle(20);

        // 6: asynchronous reset during bit 9, then a clean word
        fork
            send_word(1'b0, 16'h0F0F, odd_par(16'h0F0F), -1, 36);
            begin
                repeat (222) @(negedge clk);
                expect_eq("t6_busy_pre", busy, 1);
                rst = 1'b1;
                #1;
                expect_eq("t6_rst_req", outRequest, 0);
                expect_eq("t6_rst_busy", busy, 0);
                expect_eq("t6_rst_data", dataOut, 16'h0000);
                expect_eq("t6_rst_type", dataType, 2'd0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle(20);
        expect_eq("t6_after_rst_req", outRequest, 0);
        send_word(1'b0, 16'h5A5A, odd_par(16'h5A5A), -1, 36);
        wait_req("t6_req", 2);
        expect_eq("t6_type", dataType, WDATA);
        expect_eq("t6_data", dataOut, 16'h5A5A);
        take();
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
